// File: rtl/dct_fxp_pkg.sv
// Shared fixed-point constants and sizing helpers for the DCT datapath
// (MAC, row/column sequencers and quantiser).
package dct_fxp_pkg;

    localparam int unsigned DCT_W     = 16;
    localparam int unsigned DCT_FRAC  = 15;
    localparam int unsigned DCT_TERMS = 8;
    localparam int unsigned RC_W      = 64;

    // Accumulator width: full product plus guard bits for TERMS additions.
    function automatic int unsigned acc_w(input int unsigned w, input int unsigned terms);
        return 2 * w + $clog2(terms);
    endfunction

    // Half-LSB constant added ahead of the FRAC-bit right shift.
    function automatic logic [RC_W-1:0] round_const(input int unsigned frac);
        return (frac == 0) ? '0 : (RC_W'(1) << (frac - 1));
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational round, rescale and saturate/wrap of a wide signed accumulator
// down to a W-bit signed result.
module fxp_round_sat
    import dct_fxp_pkg::*;
#(
    parameter int unsigned W     = DCT_W,
    parameter int unsigned FRAC  = DCT_FRAC,
    parameter int unsigned ACC_W = acc_w(DCT_W, DCT_TERMS),
    parameter bit          ROUND = 1'b1,
    parameter bit          SAT   = 1'b1
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [W-1:0]     r_c,
    output logic                    ovf_c
);

    // One extra bit so the rounding add can never overflow.
    localparam int unsigned SW = ACC_W + 1;
    localparam logic signed [SW-1:0] RND = ROUND ? SW'(round_const(FRAC)) : '0;

    logic signed [SW-1:0] s;
    logic signed [SW-1:0] q;
    logic                 fits;

    always_comb begin
        s     = SW'(acc) + RND;
        q     = s >>> FRAC;
        // Result fits W bits when everything from the W-bit sign bit upward agrees.
        fits  = (&q[SW-1:W-1]) | ~(|q[SW-1:W-1]);
        ovf_c = ~fits;
        r_c   = q[W-1:0];
        if (SAT && !fits) begin
            r_c = q[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/dct_fxp_mac.sv
// Pipelined signed fixed-point multiply-accumulate for the 8-point DCT:
// S1 multiply, S2 accumulate, S3 round/saturate, one global stall.
module dct_fxp_mac
    import dct_fxp_pkg::*;
#(
    parameter int unsigned W     = DCT_W,
    parameter int unsigned FRAC  = DCT_FRAC,
    parameter int unsigned TERMS = DCT_TERMS,
    parameter bit          ROUND = 1'b1,
    parameter bit          SAT   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_r,
    output logic         out_ovf
);

    localparam int unsigned ACC_W = acc_w(W, TERMS);
    localparam int unsigned P_W   = 2 * W;
    localparam int unsigned CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TERMS - 1);

    logic                    run;
    logic                    adv;
    logic                    take;
    logic [CNT_W-1:0]        cnt;
    logic signed [P_W-1:0]   prod_c;
    logic                    close_c;

    logic                    p1_valid;
    logic                    p1_first;
    logic                    p1_close;
    logic signed [P_W-1:0]   p1_prod;

    logic signed [ACC_W-1:0] acc;
    logic                    done;

    logic [W-1:0]            r_c;
    logic                    ovf_c;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = run & adv;
    assign take     = in_valid & in_ready;
    assign prod_c   = P_W'($signed(in_a)) * P_W'($signed(in_b));
    assign close_c  = in_last | (cnt == CNT_MAX);

    // Holds in_ready low until the first clock after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Terms accepted in the open accumulation; wraps to 0 on close.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (take) begin
            cnt <= close_c ? '0 : cnt + CNT_W'(1);
        end
    end

    // S1: exact product plus framing flags for the term.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_valid <= 1'b0;
            p1_first <= 1'b0;
            p1_close <= 1'b0;
            p1_prod  <= '0;
        end else if (adv) begin
            p1_valid <= take;
            p1_first <= (cnt == '0);
            p1_close <= close_c;
            p1_prod  <= prod_c;
        end
    end

    // S2: running sum; an idle S1 leaves the partial sum untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            done <= 1'b0;
        end else if (adv) begin
            done <= p1_valid & p1_close;
            if (p1_valid) begin
                if (p1_first) begin
                    acc <= ACC_W'(p1_prod);
                end else begin
                    acc <= acc + ACC_W'(p1_prod);
                end
            end
        end
    end

    fxp_round_sat #(
        .W     (W),
        .FRAC  (FRAC),
        .ACC_W (ACC_W),
        .ROUND (ROUND),
        .SAT   (SAT)
    ) u_round_sat (
        .acc   (acc),
        .r_c   (r_c),
        .ovf_c (ovf_c)
    );

    // S3: result register, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_r     <= '0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            out_valid <= done;
            if (done) begin
                out_r   <= r_c;
                out_ovf <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_dct_fxp_mac.sv
// Bench for dct_fxp_mac: default instance plus a truncate/wrap instance on the
// same stimulus, both checked against an arithmetic reference model.
module tb_dct_fxp_mac;

    localparam int TERMS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_last, out_ready;
    logic [15:0] in_a, in_b;
    logic        in_ready, out_valid, out_ovf;
    logic [15:0] out_r;
    logic        in_ready_alt, out_valid_alt, out_ovf_alt;
    logic [15:0] out_r_alt;

    always #5 clk = ~clk;

    dct_fxp_mac dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_r(out_r), .out_ovf(out_ovf)
    );

    dct_fxp_mac #(.ROUND(1'b0), .SAT(1'b0)) dut_alt (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_alt),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid_alt),
        .out_ready(out_ready), .out_r(out_r_alt), .out_ovf(out_ovf_alt)
    );

    typedef struct {
        logic [15:0] r;
        logic        ovf;
        logic [15:0] ra;
        logic        ovfa;
    } res_t;

    int     n_cmp = 0;
    int     n_err = 0;
    int     ready_mode = 0;
    longint acc_m = 0;
    int     cnt_m = 0;
    res_t   exp_q[$];
    res_t   obs_q[$];
    logic        hold_pend = 1'b0;
    logic [15:0] hold_r;
    logic        hold_ovf;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact sum, optional half-LSB add, floor shift, clamp or wrap.
    function automatic logic [16:0] ref_out(input longint acc, input bit rnd, input bit sat);
        longint      q;
        logic [16:0] res;
        q = (acc + (rnd ? 64'sd16384 : 64'sd0)) >>> 15;
        res[16] = (q > 32767) || (q < -32768);
        if (sat && q > 32767)       res[15:0] = 16'h7FFF;
        else if (sat && q < -32768) res[15:0] = 16'h8000;
        else                        res[15:0] = q[15:0];
        return res;
    endfunction

    task automatic model_accept(input logic [15:0] a, input logic [15:0] b, input logic last);
        logic [16:0] d;
        logic [16:0] s;
        acc_m += longint'($signed(a)) * longint'($signed(b));
        cnt_m++;
        if (last || cnt_m == TERMS) begin
            d = ref_out(acc_m, 1'b1, 1'b1);
            s = ref_out(acc_m, 1'b0, 1'b0);
            exp_q.push_back('{r: d[15:0], ovf: d[16], ra: s[15:0], ovfa: s[16]});
            acc_m = 0;
            cnt_m = 0;
        end
    endtask

    function automatic logic [15:0] pick();
        int unsigned sel;
        sel = $urandom % 8;
        if (sel == 0) return 16'h7FFF;
        if (sel == 1) return 16'h8000;
        return 16'($urandom);
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) sync();
    endtask

    // Offers one term from posedge+1; it transfers at the first edge seen with in_ready high.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_last = last;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sync();
                model_accept(a, b, last);
                ok = 1'b1;
            end
        end
        if (!ok) check_eq("send_timeout", 32'(ok), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] r, input logic ovf,
                              input logic [15:0] ra, input logic ovfa);
        res_t o;
        #1;
        for (int k = 0; k < 100 && obs_q.size() == 0; k++) @(negedge clk);
        check_eq({tag, "_seen"}, 32'(obs_q.size() != 0), 32'd1);
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            check_eq({tag, "_r"},      32'(o.r),    32'(r));
            check_eq({tag, "_ovf"},    32'(o.ovf),  32'(ovf));
            check_eq({tag, "_r_alt"},  32'(o.ra),   32'(ra));
            check_eq({tag, "_ovf_alt"}, 32'(o.ovfa), 32'(ovfa));
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        sync();
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            sync();
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom % 4) != 0;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: ordering, hold-while-stalled, stall propagation.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            check_eq("alt_sync", 32'({in_ready_alt, out_valid_alt}), 32'({in_ready, out_valid}));
            if (hold_pend && out_valid) begin
                check_eq("hold_r",   32'(out_r),   32'(hold_r));
                check_eq("hold_ovf", 32'(out_ovf), 32'(hold_ovf));
            end
            if (out_valid && !out_ready) check_eq("in_ready_blk", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                obs_q.push_back('{r: out_r, ovf: out_ovf, ra: out_r_alt, ovfa: out_ovf_alt});
                check_eq("exp_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("res_r",       32'(out_r),       32'(e.r));
                    check_eq("res_ovf",     32'(out_ovf),     32'(e.ovf));
                    check_eq("res_r_alt",   32'(out_r_alt),   32'(e.ra));
                    check_eq("res_ovf_alt", 32'(out_ovf_alt), 32'(e.ovfa));
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_r    = out_r;
            hold_ovf  = out_ovf;
        end
    end

    initial begin
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_last  = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_r",     32'(out_r),     32'd0);
        check_eq("rst_out_ovf",   32'(out_ovf),   32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        check_eq("ready_pre_clk", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_eq("ready_post_clk", 32'(in_ready), 32'd1);
        sync();

        // Single Q1.15 product and its latency
        obs_q.delete();
        send(16'h4000, 16'h4000, 1'b1);
        @(negedge clk); check_eq("lat_edge0", 32'(out_valid), 32'd0);
        @(negedge clk); check_eq("lat_edge1", 32'(out_valid), 32'd0);
        @(negedge clk); check_eq("lat_edge2", 32'(out_valid), 32'd1);
        expect_out("half_sq", 16'h2000, 1'b0, 16'h2000, 1'b0);
        sync();

        // Eight full-scale products: clamp vs wrap
        obs_q.delete();
        for (int i = 0; i < 8; i++) send(16'h7FFF, 16'h7FFF, i == 7);
        expect_out("max8", 16'h7FFF, 1'b1, 16'hFFF0, 1'b1);
        sync();

        obs_q.delete();
        send(16'h8000, 16'h8000, 1'b1);
        expect_out("neg1_sq", 16'h7FFF, 1'b1, 16'h8000, 1'b1);
        sync();
        send(16'h8000, 16'h7FFF, 1'b1);
        expect_out("neg1_max", 16'h8001, 1'b0, 16'h8001, 1'b0);
        sync();

        // Rounding vs truncation at half an LSB
        send(16'h0001, 16'h4000, 1'b1);
        expect_out("rnd_pos", 16'h0001, 1'b0, 16'h0000, 1'b0);
        sync();
        send(16'hFFFF, 16'h4000, 1'b1);
        expect_out("rnd_neg", 16'h0000, 1'b0, 16'hFFFF, 1'b0);
        sync();

        // Three back-to-back accumulations with a 5-cycle downstream stall
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    int n;
                    n = $urandom_range(3, 6);
                    for (int j = 0; j < n; j++) send(pick(), pick(), j == n - 1);
                end
            end
            begin
                repeat (6) @(posedge clk);
                ready_mode = 2;
                repeat (5) @(posedge clk);
                ready_mode = 0;
            end
        join
        drain();

        // Reset in the middle of an accumulation discards the partial sum
        for (int i = 0; i < 4; i++) send(pick(), pick(), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        acc_m = 0;
        cnt_m = 0;
        exp_q.delete();
        obs_q.delete();
        repeat (2) @(negedge clk);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(in_ready),  32'd0);
        check_eq("mid_rst_r",     32'(out_r),     32'd0);
        rst = 1'b0;
        @(negedge clk);
        sync();
        send(16'h4000, 16'h4000, 1'b1);
        expect_out("post_rst", 16'h2000, 1'b0, 16'h2000, 1'b0);
        sync();

        // Nine terms without in_last: close after the 8th, 9th opens a new sum
        obs_q.delete();
        for (int i = 0; i < 8; i++) send(16'h4000, 16'h4000, 1'b0);
        send(16'h4000, 16'h2000, 1'b0);
        send(16'h0001, 16'h4000, 1'b1);
        expect_out("auto_close", 16'h7FFF, 1'b1, 16'h0000, 1'b1);
        expect_out("after_auto", 16'h1001, 1'b0, 16'h1000, 1'b0);
        sync();
        drain();

        // Random stream with bubbles and random backpressure
        ready_mode = 1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom % 4 == 0) idle(int'($urandom_range(1, 3)));
            send(pick(), pick(), ($urandom % 6) == 0);
        end
        send(16'h0100, 16'h0100, 1'b1);
        drain();
        ready_mode = 0;
        sync();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
